// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP-1.5 control path.
//   opcode_t    - 4-bit instruction opcodes (IR[7:4])
//   step_t      - micro-step counter type, with T0..T4 constants
//   ctrl_word_t - every datapath strobe in one packed word
//   CTRL_NOP    - control word with every strobe low
package sap_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_LDB = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_STA = 4'h5,
    OP_LDI = 4'h6,
    OP_JMP = 4'h7,
    OP_JC  = 4'h8,
    OP_JZ  = 4'h9,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef logic [2:0] step_t;

  localparam step_t STEP_T0 = 3'd0;
  localparam step_t STEP_T1 = 3'd1;
  localparam step_t STEP_T2 = 3'd2;
  localparam step_t STEP_T3 = 3'd3;
  // T4 exists in the encoding but no instruction uses it.
  localparam step_t STEP_T4 = 3'd4;

  typedef struct packed {
    logic pc_inc;
    logic pc_load;
    logic pc_oe;
    logic mar_load;
    logic ram_oe;
    logic ram_we;
    logic ir_load;
    logic ir_oe;
    logic a_load;
    logic a_oe;
    logic b_load;
    logic alu_oe;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// microcode_rom: combinational decode of (opcode, step, flags) into the
// control word for the current micro-step.
//   opcode     in  4 - IR[7:4]; only consulted from T2 onward
//   step       in  3 - current micro-step
//   flag_zero  in  1 - registered Z flag
//   flag_carry in  1 - registered C flag
//   ctrl       out   - strobes for this step
//   last_step  out 1 - this step ends the instruction (next step is T0)
module microcode_rom
  import sap_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  step,
  input  logic        flag_zero,
  input  logic        flag_carry,
  output ctrl_word_t  ctrl,
  output logic        last_step
);

  opcode_t op;
  assign op = opcode_t'(opcode);

  always_comb begin
    ctrl      = CTRL_NOP;
    last_step = 1'b0;
    case (step)
      STEP_T0: begin
        ctrl.pc_oe    = 1'b1;
        ctrl.mar_load = 1'b1;
      end
      STEP_T1: begin
        ctrl.ram_oe  = 1'b1;
        ctrl.ir_load = 1'b1;
        ctrl.pc_inc  = 1'b1;
      end
      STEP_T2: begin
        // Most instructions finish here; the memory-operand ones clear it.
        last_step = 1'b1;
        case (op)
          OP_LDA, OP_LDB, OP_STA: begin
            ctrl.ir_oe    = 1'b1;
            ctrl.mar_load = 1'b1;
            last_step     = 1'b0;
          end
          OP_ADD: begin
            ctrl.alu_oe     = 1'b1;
            ctrl.a_load     = 1'b1;
            ctrl.flags_load = 1'b1;
          end
          OP_SUB: begin
            ctrl.alu_oe     = 1'b1;
            ctrl.alu_sub    = 1'b1;
            ctrl.a_load     = 1'b1;
            ctrl.flags_load = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_oe  = 1'b1;
            ctrl.a_load = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_oe   = 1'b1;
            ctrl.pc_load = 1'b1;
          end
          OP_JC: begin
            ctrl.ir_oe   = flag_carry;
            ctrl.pc_load = flag_carry;
          end
          OP_JZ: begin
            ctrl.ir_oe   = flag_zero;
            ctrl.pc_load = flag_zero;
          end
          OP_OUT: begin
            ctrl.a_oe     = 1'b1;
            ctrl.out_load = 1'b1;
          end
          // NOP, HLT and the undefined opcodes issue nothing.
          default: ;
        endcase
      end
      STEP_T3: begin
        last_step = 1'b1;
        case (op)
          OP_LDA: begin
            ctrl.ram_oe = 1'b1;
            ctrl.a_load = 1'b1;
          end
          OP_LDB: begin
            ctrl.ram_oe = 1'b1;
            ctrl.b_load = 1'b1;
          end
          OP_STA: begin
            ctrl.a_oe   = 1'b1;
            ctrl.ram_we = 1'b1;
          end
          default: ;
        endcase
      end
      // T4 and above are unreachable; force a return to fetch if ever seen.
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: micro-step sequencer for the SAP-1.5 datapath.
//   clk, reset            - system clock; async active-high reset
//   opcode                - IR[7:4]
//   flag_zero, flag_carry - registered flags, sampled combinationally at T2
//   pc_inc/pc_load/pc_oe, mar_load, ram_oe/ram_we, ir_load/ir_oe,
//   a_load/a_oe, b_load, alu_oe/alu_sub, flags_load, out_load
//                         - datapath strobes (at most one bus driver high)
//   halted                - high once HLT has executed, until reset
//   step                  - current micro-step (debug)
module control_sequencer
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       flag_zero,
  input  logic       flag_carry,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       pc_oe,
  output logic       mar_load,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       ir_load,
  output logic       ir_oe,
  output logic       a_load,
  output logic       a_oe,
  output logic       b_load,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] step
);

  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;
  ctrl_word_t rom_ctrl;
  ctrl_word_t ctrl;
  logic       rom_last;

  microcode_rom u_rom (
    .opcode     (opcode),
    .step       (step_q),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .ctrl       (rom_ctrl),
    .last_step  (rom_last)
  );

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if ((step_q == STEP_T2) && (opcode == OP_HLT)) begin
        halted_d = 1'b1;
        step_d   = STEP_T0;
      end else if (rom_last) begin
        step_d = STEP_T0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= STEP_T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // The step register already sits at T0 during reset, so the fetch strobes
  // must be masked here, not in the ROM, to keep the bus quiet until release.
  always_comb begin
    ctrl = rom_ctrl;
    if (reset || halted_q) begin
      ctrl = CTRL_NOP;
    end
  end

  assign pc_inc     = ctrl.pc_inc;
  assign pc_load    = ctrl.pc_load;
  assign pc_oe      = ctrl.pc_oe;
  assign mar_load   = ctrl.mar_load;
  assign ram_oe     = ctrl.ram_oe;
  assign ram_we     = ctrl.ram_we;
  assign ir_load    = ctrl.ir_load;
  assign ir_oe      = ctrl.ir_oe;
  assign a_load     = ctrl.a_load;
  assign a_oe       = ctrl.a_oe;
  assign b_load     = ctrl.b_load;
  assign alu_oe     = ctrl.alu_oe;
  assign alu_sub    = ctrl.alu_sub;
  assign flags_load = ctrl.flags_load;
  assign out_load   = ctrl.out_load;
  assign halted     = halted_q;
  assign step       = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench for control_sequencer, with a small
// behavioural SAP datapath (PC, MAR, RAM, IR, A, B, ALU, flags, OUT) that
// reacts to the strobes so whole programs can be executed.
`timescale 1ns/1ps
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode;
  logic       flag_zero, flag_carry;
  logic       pc_inc, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe;
  logic       a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load;
  logic       halted;
  logic [2:0] step;

  int n_checks = 0;
  int n_pass   = 0;
  int we_pulses = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_oe(pc_oe), .mar_load(mar_load),
    .ram_oe(ram_oe), .ram_we(ram_we), .ir_load(ir_load), .ir_oe(ir_oe),
    .a_load(a_load), .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe),
    .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
    .halted(halted), .step(step)
  );

  // Strobe vector bit positions.
  localparam logic [14:0] S_PC_INC   = 15'h4000;
  localparam logic [14:0] S_PC_LOAD  = 15'h2000;
  localparam logic [14:0] S_PC_OE    = 15'h1000;
  localparam logic [14:0] S_MAR_LOAD = 15'h0800;
  localparam logic [14:0] S_RAM_OE   = 15'h0400;
  localparam logic [14:0] S_RAM_WE   = 15'h0200;
  localparam logic [14:0] S_IR_LOAD  = 15'h0100;
  localparam logic [14:0] S_IR_OE    = 15'h0080;
  localparam logic [14:0] S_A_LOAD   = 15'h0040;
  localparam logic [14:0] S_A_OE     = 15'h0020;
  localparam logic [14:0] S_B_LOAD   = 15'h0010;
  localparam logic [14:0] S_ALU_OE   = 15'h0008;
  localparam logic [14:0] S_ALU_SUB  = 15'h0004;
  localparam logic [14:0] S_FLAGS_LD = 15'h0002;
  localparam logic [14:0] S_OUT_LOAD = 15'h0001;
  localparam logic [14:0] S_FETCH0   = S_PC_OE | S_MAR_LOAD;
  localparam logic [14:0] S_FETCH1   = S_RAM_OE | S_IR_LOAD | S_PC_INC;

  logic [14:0] sv;
  assign sv = {pc_inc, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe,
               a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load};

  // Behavioural datapath.
  logic       dp_mode = 1'b0;
  logic [3:0] op_drv = 4'h0;
  logic       zf_drv = 1'b0, cf_drv = 1'b0;
  logic [7:0] ram [0:15];
  logic [3:0] pc, mar;
  logic [7:0] ir, a, b, out_reg, bus;
  logic       z, c;
  logic [8:0] alu;

  always_comb begin
    alu = alu_sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    bus = 8'h00;
    if (pc_oe)  bus = {4'h0, pc};
    if (ram_oe) bus = ram[mar];
    if (ir_oe)  bus = {4'h0, ir[3:0]};
    if (a_oe)   bus = a;
    if (alu_oe) bus = alu[7:0];
  end

  assign opcode     = dp_mode ? ir[7:4] : op_drv;
  assign flag_zero  = dp_mode ? z : zf_drv;
  assign flag_carry = dp_mode ? c : cf_drv;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= 4'h0; mar <= 4'h0; ir <= 8'h00; a <= 8'h00; b <= 8'h00;
      out_reg <= 8'h00; z <= 1'b0; c <= 1'b0;
    end else begin
      if (pc_inc)     pc <= pc + 4'd1;
      if (pc_load)    pc <= bus[3:0];
      if (mar_load)   mar <= bus[3:0];
      if (ram_we)     ram[mar] <= bus;
      if (ir_load)    ir <= bus;
      if (a_load)     a <= bus;
      if (b_load)     b <= bus;
      if (out_load)   out_reg <= bus;
      if (flags_load) begin z <= (alu[7:0] == 8'h00); c <= alu[8]; end
    end
  end

  always @(posedge clk) if (ram_we) we_pulses++;

  // Bus and strobe invariants, every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if ((int'(pc_oe) + int'(ram_oe) + int'(ir_oe) + int'(a_oe) + int'(alu_oe)) > 1 ||
          (ram_we && ram_oe) || (pc_inc && pc_load))
        $display("FAIL invariant: strobes=%h step=%0d violate bus/strobe exclusivity", sv, step);
      else n_pass++;
    end
  end

  function automatic logic [14:0] exp_t2(input logic [3:0] op, input logic zf, input logic cf);
    case (op)
      4'h1, 4'h2, 4'h5: return S_IR_OE | S_MAR_LOAD;
      4'h3: return S_ALU_OE | S_A_LOAD | S_FLAGS_LD;
      4'h4: return S_ALU_OE | S_ALU_SUB | S_A_LOAD | S_FLAGS_LD;
      4'h6: return S_IR_OE | S_A_LOAD;
      4'h7: return S_IR_OE | S_PC_LOAD;
      4'h8: return cf ? (S_IR_OE | S_PC_LOAD) : 15'h0000;
      4'h9: return zf ? (S_IR_OE | S_PC_LOAD) : 15'h0000;
      4'hE: return S_A_OE | S_OUT_LOAD;
      default: return 15'h0000;
    endcase
  endfunction

  function automatic logic [14:0] exp_t3(input logic [3:0] op);
    case (op)
      4'h1: return S_RAM_OE | S_A_LOAD;
      4'h2: return S_RAM_OE | S_B_LOAD;
      4'h5: return S_A_OE | S_RAM_WE;
      default: return 15'h0000;
    endcase
  endfunction

  // Holds reset for 3 cycles and releases it just after a rising edge, so
  // the next half cycle observed is T0 of the first instruction.
  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
  endtask

  task automatic test_reset();
    dp_mode = 1'b0; op_drv = 4'h0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (sv !== 15'h0000) $display("FAIL reset_strobes: got %h want 0000", sv); else n_pass++;
      n_checks++; if (step !== 3'd0) $display("FAIL reset_step: got %0d want 0", step); else n_pass++;
      n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (sv !== S_FETCH0) $display("FAIL reset_t0: got %h want %h", sv, S_FETCH0); else n_pass++;
    @(negedge clk);
    n_checks++; if (sv !== S_FETCH1) $display("FAIL reset_t1: got %h want %h", sv, S_FETCH1); else n_pass++;
    n_checks++; if (step !== 3'd1) $display("FAIL reset_t1_step: got %0d want 1", step); else n_pass++;
  endtask

  task automatic test_opcode_sweep();
    logic [3:0] op;
    dp_mode = 1'b0; zf_drv = 1'b0; cf_drv = 1'b0; op_drv = 4'h0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      op = 4'(i);
      @(negedge clk);
      n_checks++; if (step !== 3'd0 || sv !== S_FETCH0)
        $display("FAIL sweep_t0 op=%h: got step=%0d strobes=%h want step=0 strobes=%h", op, step, sv, S_FETCH0); else n_pass++;
      op_drv = ~op;  // opcode during fetch must be ignored
      @(negedge clk);
      n_checks++; if (step !== 3'd1 || sv !== S_FETCH1)
        $display("FAIL sweep_t1 op=%h: got step=%0d strobes=%h want step=1 strobes=%h", op, step, sv, S_FETCH1); else n_pass++;
      op_drv = op;
      @(negedge clk);
      n_checks++; if (step !== 3'd2 || sv !== exp_t2(op, 1'b0, 1'b0))
        $display("FAIL sweep_t2 op=%h: got step=%0d strobes=%h want step=2 strobes=%h", op, step, sv, exp_t2(op, 1'b0, 1'b0)); else n_pass++;
      if (op == 4'h1 || op == 4'h2 || op == 4'h5) begin
        @(negedge clk);
        n_checks++; if (step !== 3'd3 || sv !== exp_t3(op))
          $display("FAIL sweep_t3 op=%h: got step=%0d strobes=%h want step=3 strobes=%h", op, step, sv, exp_t3(op)); else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++; if (halted !== 1'b1 || sv !== 15'h0000 || step !== 3'd0)
      $display("FAIL sweep_halt: got halted=%b strobes=%h step=%0d want 1/0000/0", halted, sv, step); else n_pass++;
    // Flag-dependent jumps with the flag set, driven directly.
    zf_drv = 1'b1; cf_drv = 1'b1; op_drv = 4'h8;
    do_reset();
    repeat (2) @(negedge clk);
    @(negedge clk);
    n_checks++; if (sv !== (S_IR_OE | S_PC_LOAD)) $display("FAIL sweep_jc_taken: got %h want %h", sv, S_IR_OE | S_PC_LOAD); else n_pass++;
    op_drv = 4'h9; cf_drv = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    n_checks++; if (sv !== (S_IR_OE | S_PC_LOAD)) $display("FAIL sweep_jz_taken: got %h want %h", sv, S_IR_OE | S_PC_LOAD); else n_pass++;
  endtask

  task automatic test_program();
    int bad;
    dp_mode = 1'b1;
    clear_ram();
    ram[0] = 8'h1E; ram[1] = 8'h2F; ram[2] = 8'h30; ram[3] = 8'hE0; ram[4] = 8'hF0;
    ram[14] = 8'h22; ram[15] = 8'h22;
    do_reset();
    repeat (16) @(posedge clk);
    @(negedge clk);
    n_checks++; if (halted !== 1'b0 || step !== 3'd2)
      $display("FAIL prog_cycle17: got halted=%b step=%0d want 0/2", halted, step); else n_pass++;
    @(negedge clk);
    n_checks++; if (halted !== 1'b1) $display("FAIL prog_halted: got %b want 1", halted); else n_pass++;
    n_checks++; if (a !== 8'h44) $display("FAIL prog_a: got %h want 44", a); else n_pass++;
    n_checks++; if (out_reg !== 8'h44) $display("FAIL prog_out: got %h want 44", out_reg); else n_pass++;
    n_checks++; if (pc !== 4'h5) $display("FAIL prog_pc: got %h want 5", pc); else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted !== 1'b1 || sv !== 15'h0000) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL prog_stay_halted: got %0d bad cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_cond_jump(input logic [3:0] jop, input logic take);
    logic [3:0] jaddr;
    logic       found;
    dp_mode = 1'b1;
    clear_ram();
    if (take) begin
      ram[0] = 8'h1E; ram[1] = 8'h2F;
      if (jop == 4'h9) begin ram[2] = 8'h40; ram[14] = 8'h10; ram[15] = 8'h10; end
      else             begin ram[2] = 8'h30; ram[14] = 8'hFF; ram[15] = 8'h01; end
      jaddr = 4'd3;
    end else begin
      jaddr = 4'd0;
    end
    ram[jaddr] = {jop, 4'h5};
    ram[jaddr + 4'd1] = 8'hF0;
    ram[5] = 8'hF0;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (step == 3'd2 && ir == {jop, 4'h5}) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) $display("FAIL jump_%h_%b_reach_t2: got %b want 1", jop, take, found); else n_pass++;
    if (found) begin
      n_checks++; if (pc_load !== take) $display("FAIL jump_%h_%b_pc_load: got %b want %b", jop, take, pc_load, take); else n_pass++;
      n_checks++; if (sv !== (take ? (S_IR_OE | S_PC_LOAD) : 15'h0000))
        $display("FAIL jump_%h_%b_strobes: got %h want %h", jop, take, sv, take ? (S_IR_OE | S_PC_LOAD) : 15'h0000); else n_pass++;
      if (take) begin
        n_checks++; if (bus !== 8'h05) $display("FAIL jump_%h_bus: got %h want 05", jop, bus); else n_pass++;
      end
      @(negedge clk);
      n_checks++; if (step !== 3'd0 || pc !== (take ? 4'h5 : jaddr + 4'd1))
        $display("FAIL jump_%h_%b_next_pc: got step=%0d pc=%h want 0/%h", jop, take, step, pc, take ? 4'h5 : jaddr + 4'd1); else n_pass++;
      n_checks++; if (bus !== {4'h0, (take ? 4'h5 : jaddr + 4'd1)})
        $display("FAIL jump_%h_%b_fetch_addr: got %h want %h", jop, take, bus, {4'h0, (take ? 4'h5 : jaddr + 4'd1)}); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sta();
    dp_mode = 1'b0; op_drv = 4'h5;
    do_reset();
    repeat (2) @(negedge clk);
    @(negedge clk);
    n_checks++; if (step !== 3'd2 || sv !== (S_IR_OE | S_MAR_LOAD))
      $display("FAIL mid_sta_t2: got step=%0d strobes=%h want 2/%h", step, sv, S_IR_OE | S_MAR_LOAD); else n_pass++;
    @(posedge clk); #1 reset = 1'b1;
    we_pulses = 0;
    #1;
    n_checks++; if (step !== 3'd0 || sv !== 15'h0000)
      $display("FAIL mid_sta_abort: got step=%0d strobes=%h want 0/0000", step, sv); else n_pass++;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    n_checks++; if (we_pulses != 0) $display("FAIL mid_sta_we: got %0d write edges want 0", we_pulses); else n_pass++;
    @(negedge clk);
    n_checks++; if (step !== 3'd0 || sv !== S_FETCH0)
      $display("FAIL mid_sta_restart_t0: got step=%0d strobes=%h want 0/%h", step, sv, S_FETCH0); else n_pass++;
    @(negedge clk);
    n_checks++; if (step !== 3'd1 || sv !== S_FETCH1)
      $display("FAIL mid_sta_restart_t1: got step=%0d strobes=%h want 1/%h", step, sv, S_FETCH1); else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ram();
    test_reset();
    test_opcode_sweep();
    test_program();
    test_cond_jump(4'h9, 1'b0);
    test_cond_jump(4'h9, 1'b1);
    test_cond_jump(4'h8, 1'b0);
    test_cond_jump(4'h8, 1'b1);
    test_reset_mid_sta();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the 8-bit SAP-1.5 computer. It steps a per-instruction micro-step counter, decodes the opcode nibble latched in the instruction register, and drives every load/output-enable strobe on the shared 8-bit bus. These strobes cover the PC, MAR, RAM, IR, A, B, ALU, flags and output register, so it sequences the whole datapath. It sits beside the datapath inside `computer` and owns bus arbitration: at most one bus driver per cycle.

## Interface
No parameters; opcode encodings and control-word layout come from the shared package.
- `clk` in 1 — system clock, all state changes on rising edge
- `reset` in 1 — asynchronous, active-high; clears sequencer state
- `opcode` in 4 — IR[7:4], valid from step 2 onward
- `flag_zero` in 1 — registered Z flag from flags register
- `flag_carry` in 1 — registered C flag from flags register
- `pc_inc`, `pc_load`, `pc_oe` out 1 each — program counter controls
- `mar_load` out 1 — memory address register load
- `ram_oe`, `ram_we` out 1 each — RAM read-drive / write
- `ir_load`, `ir_oe` out 1 each — IR load; IR drives operand nibble, zero-extended, onto bus
- `a_load`, `a_oe`, `b_load` out 1 each — register A/B controls
- `alu_oe`, `alu_sub` out 1 each — ALU result to bus; subtract select
- `flags_load`, `out_load` out 1 each — latch Z/C; latch output register
- `halted` out 1 — high in HALT state
- `step` out 3 — current micro-step, for debug/bench

## Operation
- States: micro-step T0..T4 plus HALT. Control outputs are combinational from (step, opcode, flags).
- Fetch, common to all instructions:
  - T0: `pc_oe`, `mar_load`.
  - T1: `ram_oe`, `ir_load`, `pc_inc`.
- Execute from T2. Last listed step returns to T0 on the next edge.
  - NOP (0x0) and undefined opcodes 0xA–0xD: T2 no strobes.
  - LDA (0x1): T2 `ir_oe`,`mar_load`; T3 `ram_oe`,`a_load`.
  - LDB (0x2): as LDA, with `b_load`.
  - ADD (0x3): T2 `alu_oe`,`a_load`,`flags_load`.
  - SUB (0x4): as ADD, plus `alu_sub`.
  - STA (0x5): T2 `ir_oe`,`mar_load`; T3 `a_oe`,`ram_we`.
  - LDI (0x6): T2 `ir_oe`,`a_load`.
  - JMP (0x7): T2 `ir_oe`,`pc_load`.
  - JC (0x8) / JZ (0x9): T2 `ir_oe`,`pc_load` only if `flag_carry` / `flag_zero` is 1 at T2; otherwise no strobes.
  - OUT (0xE): T2 `a_oe`,`out_load`.
  - HLT (0xF): T2 no strobes; next state HALT.
- HALT: all strobes 0, `halted`=1. Left only by reset.
- Invariants, every cycle:
  - At most one of `pc_oe`,`ram_oe`,`ir_oe`,`a_oe`,`alu_oe` is high.
  - `ram_we` and `ram_oe` are never both high.
  - `pc_inc` and `pc_load` are never both high.

## Timing
- Reset value: step=0, `halted`=0. While `reset`=1 every strobe output is forced to 0, including the T0 fetch strobes.
- First fetch strobes appear in the cycle after `reset` deasserts.
- Reset mid-instruction abandons it immediately. No partial strobe follows.
- Instruction lengths: NOP, undefined, ADD, SUB, LDI, JMP, JC, JZ and OUT take 3 cycles. LDA, LDB and STA take 4. HLT takes 3 cycles to reach HALT.
- Load strobes take effect on the rising edge that ends the step. A jump is therefore visible at the next T0.
- Flags are sampled combinationally at T2. Flags written by ADD/SUB are valid for a JC/JZ that immediately follows.
- `opcode` is ignored in T0/T1.
- Step counter never exceeds 3. Value 4 is reserved.

## Structure
- Package `sap_pkg`:
  - `opcode_t` enum with the encodings above.
  - `step_t`.
  - packed struct `ctrl_word_t` holding all strobes, with constant `CTRL_NOP` (all zeros).
- Sub-module `microcode_rom`: purely combinational (`opcode`, `step`, `flag_zero`, `flag_carry`) → (`ctrl_word_t`, `last_step`).
- `control_sequencer`: owns the step register and HALT bit, applies reset gating, and unpacks the control word to ports.

## Test plan
- Reset held 3 cycles, then released: all strobes 0 during reset; T0 gives `pc_oe`=`mar_load`=1; T1 gives `ram_oe`=`ir_load`=`pc_inc`=1.
- Program LDA 0xE; LDB 0xF; ADD; OUT; HLT with RAM[E]=0x22, RAM[F]=0x22: A=0x44 and out=0x44; `halted`=1 after 17 cycles and stays high for 20 more cycles.
- Opcode sweep 0x0–0xF: strobe sequence matches the Operation list exactly; bus-driver one-hot invariant asserted every cycle.
- JZ 0x5 with Z=0 → PC unchanged and `pc_load`=0. With Z=1 → `pc_load`=1, bus=0x05, next fetch address 0x5. Same pair for JC with C.
- SUB producing 0 (A=0x10, B=0x10) followed by JZ: the jump is taken, confirming same-cycle flag visibility.
- Reset asserted at T3 of STA: `ram_we` never pulses and step=0 immediately. After release, fetch restarts from T0.
